cle_sram_arbiter: RTL and testbench

Single-port label-SRAM controller for the connected-component labeling subsystem, for a 32x32 image with 1024 8-bit label entries. It shares the SRAM between two requesters: r0 is the labeling engine and r1 is the host readback / relabel unit. It also contains a built-in clear sequencer that zero-fills the whole array before a new image. It sits between the requesters and the sram_a/sram_d/sram_wen/sram_q pins.

---
 rtl/cle_pkg.sv | 13 +
 rtl/cle_rr_arb2.sv | 26 ++
 rtl/cle_sram_arbiter.sv | 117 +++++++++++
 tb/tb_cle_sram_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cle_pkg.sv
// Shared constants and types for the connected-component labeling label-SRAM path.
package cle_pkg;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = IMG_W * IMG_H;

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  localparam int REQ_LBL  = 0;
  localparam int REQ_HOST = 1;
endpackage

// File: rtl/cle_rr_arb2.sv
// Two-way round-robin grant logic; the pointer flips to the other requester after every grant.
module cle_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  import cle_pkg::*;

  logic ptr;  // requester favoured under contention

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req[REQ_LBL] && (!req[REQ_HOST] || !ptr)) gnt[REQ_LBL] = 1'b1;
      else if (req[REQ_HOST])                       gnt[REQ_HOST] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               ptr <= 1'b0;
    else if (gnt[REQ_LBL])   ptr <= 1'b1;
    else if (gnt[REQ_HOST])  ptr <= 1'b0;
  end
endmodule

// File: rtl/cle_sram_arbiter.sv
// Label-SRAM controller: round-robin sharing between labeling engine and host,
// plus a sequencer that zero-fills the whole array before a new image.
module cle_sram_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int DEPTH     = 1024,
  parameter int CLR_VALUE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic [DW-1:0] sram_q,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_wen
);
  import cle_pkg::*;

  state_t        state;
  logic [AW:0]   cnt;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  // Read tracking: stage 1 = address on the SRAM pins, stage 2 = sram_q valid.
  logic          rd_v1, rd_o1, rd_v2, rd_o2;

  assign arb_en = (state == ST_ARB) && !reset;

  cle_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (arb_en),
    .req    ({r1_req, r0_req}),
    .gnt    (gnt)
  );

  assign r0_gnt    = gnt[REQ_LBL];
  assign r1_gnt    = gnt[REQ_HOST];
  assign acc_we    = gnt[REQ_HOST] ? r1_we    : r0_we;
  assign acc_addr  = gnt[REQ_HOST] ? r1_addr  : r0_addr;
  assign acc_wdata = gnt[REQ_HOST] ? r1_wdata : r0_wdata;

  assign r0_rvalid = rd_v2 && !rd_o2;
  assign r1_rvalid = rd_v2 && rd_o2;
  assign r0_rdata  = sram_q;
  assign r1_rdata  = sram_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_ARB;
      cnt      <= '0;
      sram_a   <= '0;
      sram_d   <= '0;
      sram_wen <= 1'b1;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      rd_v1    <= 1'b0;
      rd_o1    <= 1'b0;
      rd_v2    <= 1'b0;
      rd_o2    <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      rd_v1    <= (|gnt) && !acc_we;
      rd_o1    <= gnt[REQ_HOST];
      rd_v2    <= rd_v1;
      rd_o2    <= rd_o1;
      case (state)
        ST_ARB: begin
          if (|gnt) begin
            sram_a   <= acc_addr;
            sram_d   <= acc_wdata;
            sram_wen <= ~acc_we;
          end else begin
            sram_wen <= 1'b1;
          end
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_busy <= 1'b1;
            cnt      <= '0;
          end
        end
        ST_CLEAR: begin
          sram_a   <= cnt[AW-1:0];
          sram_d   <= DW'(CLR_VALUE);
          sram_wen <= 1'b0;
          // Stop on the last entry rather than on counter wrap.
          if (cnt == (AW+1)'(DEPTH-1)) begin
            state    <= ST_ARB;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_cle_sram_arbiter.sv
// Directed bench for cle_sram_arbiter with a behavioural one-cycle-latency SRAM.
module tb_cle_sram_arbiter;
  import cle_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0, clr_start = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, clr_busy, clr_done, sram_wen;
  logic [DW-1:0] r0_rdata, r1_rdata, sram_d, sram_q;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cle_sram_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .sram_q(sram_q), .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen)
  );

  always @(posedge clk) begin
    if (!sram_wen) mem[sram_a] <= sram_d;
    sram_q <= mem[sram_a];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a, nw, bad, gbad, ndone, done_a, cnt_rv;
    logic seen, fin, r0_after, hit;
    logic eg0, eg1, ev0, ev1;

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + i[7:0];

    // Reset: grants forced low even with a request pending
    r0_req = 1;
    repeat (2) @(posedge clk);
    #1;
    check("gnt_in_reset", r0_gnt, 0);
    check("wen_in_reset", sram_wen, 1);
    r0_req = 0;
    reset = 0;
    @(negedge clk);
    check("rst_wen", sram_wen, 1);
    check("rst_addr", sram_a, 0);
    check("rst_gnt", {r0_gnt, r1_gnt}, 2'b00);
    check("rst_busy", clr_busy, 0);
    check("rst_done", clr_done, 0);
    check("rst_rvalid", {r0_rvalid, r1_rvalid}, 2'b00);
    $display("tx reset released");

    // r0 write then read back-to-back
    tick; r0_req = 1; r0_we = 1; r0_addr = 5; r0_wdata = 8'h07;
    @(negedge clk); check("wr_gnt", r0_gnt, 1);
    tick; r0_we = 0;
    @(negedge clk);
    check("rd_gnt", r0_gnt, 1);
    check("wr_pins", {sram_wen, 2'b00, sram_a, sram_d}, {1'b0, 2'b00, 10'd5, 8'h07});
    tick; r0_req = 0;
    @(negedge clk);
    check("rd_pins", {sram_wen, sram_a}, {1'b1, 10'd5});
    check("rv_early", r0_rvalid, 0);
    tick;
    @(negedge clk);
    check("rv0", {r0_rvalid, r1_rvalid}, 2'b10);
    check("rdata0", r0_rdata, 8'h07);
    check("idle_wen", sram_wen, 1);
    $display("tx r0 write/read addr 5 data 0x%0h", r0_rdata);

    // r1 single read, also returns the pointer to r0
    tick; r1_req = 1; r1_we = 0; r1_addr = 3;
    @(negedge clk); check("r1_gnt", {r0_gnt, r1_gnt}, 2'b01);
    tick; r1_req = 0;
    tick;
    @(negedge clk);
    check("rv1", {r0_rvalid, r1_rvalid}, 2'b01);
    check("rdata1", r1_rdata, 8'h13);
    $display("tx r1 read addr 3 data 0x%0h", r1_rdata);

    // Contention: strict alternation starting with r0
    for (int k = 0; k < 6; k++) begin
      tick;
      r0_req = (k < 4); r0_we = 0; r0_addr = 1;
      r1_req = (k < 4); r1_we = 0; r1_addr = 2;
      eg0 = (k < 4) && (k % 2 == 0);
      eg1 = (k < 4) && (k % 2 == 1);
      ev0 = (k >= 2) && (k % 2 == 0);
      ev1 = (k >= 2) && (k % 2 == 1);
      @(negedge clk);
      check($sformatf("cont_gnt%0d", k), {r0_gnt, r1_gnt}, {eg0, eg1});
      check($sformatf("cont_rv%0d", k), {r0_rvalid, r1_rvalid}, {ev0, ev1});
      if (ev0) check($sformatf("cont_rd0_%0d", k), r0_rdata, 8'h11);
      if (ev1) check($sformatf("cont_rd1_%0d", k), r1_rdata, 8'h12);
      $display("tx contention cycle %0d gnt=%b%b", k, r0_gnt, r1_gnt);
    end

    // Clear sweep with r0 waiting and a second clr_start at address 500
    tick; clr_start = 1; r0_req = 0; r1_req = 0;
    @(negedge clk); check("pre_busy", clr_busy, 0);
    tick; clr_start = 0; r0_req = 1; r0_we = 0; r0_addr = 7;
    exp_a = 0; nw = 0; bad = 0; gbad = 0; ndone = 0; done_a = 0;
    seen = 0; fin = 0; r0_after = 0;
    for (int c = 0; c < 1200 && !fin; c++) begin
      @(negedge clk);
      if (!sram_wen) begin
        if (sram_a !== exp_a[AW-1:0] || sram_d !== 8'h00) bad++;
        exp_a++;
        nw++;
      end
      if (clr_busy && (r0_gnt || r1_gnt)) gbad++;
      if (clr_done) begin ndone++; done_a = sram_a; end
      if (clr_busy) seen = 1;
      else if (seen) begin fin = 1; r0_after = r0_gnt; end
      if (!fin) begin
        tick;
        clr_start = (!sram_wen && sram_a == 10'd500);
      end
    end
    check("clr_finished", fin, 1);
    check("clr_writes", nw, 1024);
    check("clr_seq_err", bad, 0);
    check("clr_gnt_busy", gbad, 0);
    check("clr_done_cnt", ndone, 1);
    check("clr_done_addr", done_a, 1023);
    check("gnt_after_clr", r0_after, 1);
    $display("tx clear sweep writes=%0d done=%0d", nw, ndone);
    tick; r0_req = 0;
    tick;
    @(negedge clk);
    check("rd_cleared_rv", r0_rvalid, 1);
    check("rd_cleared_data", r0_rdata, 8'h00);

    // Reset mid-sweep at address 300
    tick; clr_start = 1;
    tick; clr_start = 0;
    hit = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      tick;
      if (!sram_wen && sram_a == 10'd300) hit = 1;
    end
    check("sweep_300", hit, 1);
    reset = 1; r0_req = 1; r1_req = 1; r1_addr = 2;
    #1;
    check("mid_rst_pins", {sram_wen, sram_a, sram_d}, {1'b1, 10'd0, 8'h00});
    check("mid_rst_busy", clr_busy, 0);
    check("mid_rst_gnt", {r0_gnt, r1_gnt}, 2'b00);
    tick; tick; reset = 0;
    @(negedge clk);
    check("post_rst_gnt", {r0_gnt, r1_gnt}, 2'b10);
    check("post_rst_busy", clr_busy, 0);
    $display("tx reset during sweep");
    tick; r0_req = 0; r1_req = 0;
    repeat (3) tick;

    // Reset with an r1 read in flight
    r1_req = 1; r1_we = 0; r1_addr = 3;
    @(negedge clk); check("flight_gnt", r1_gnt, 1);
    tick; r1_req = 0; reset = 1;
    tick; reset = 0;
    cnt_rv = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (r0_rvalid || r1_rvalid) cnt_rv++;
    end
    check("flight_dropped", cnt_rv, 0);
    $display("tx reset with read in flight");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
